// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the shift-add multiplier.
// start is a level request; the multiplier accepts it only in IDLE or DONE.
interface shift_add_multiplier_if #(
  parameter int SIZE = 8
);
  logic              start;
  logic [SIZE-1:0]   multiplicand;
  logic [SIZE-1:0]   multiplier;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned SIZE x SIZE multiplier: one ripple-carry adder, one add/shift per cycle.
// Handshake: start is sampled on each rising edge in IDLE or DONE; done pulses once per product.

module parametric_RCA #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] x,
  input  logic [SIZE-1:0] y,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);
  logic [SIZE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[SIZE];
endmodule

module shift_add_multiplier #(
  parameter int SIZE = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  shift_add_multiplier_if.slave      bus,
  output logic [1:0]                 state_o
);
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [SIZE-1:0]   a_q;
  logic [SIZE-1:0]   p_hi_q;
  logic [SIZE-1:0]   q_q;
  logic [CW-1:0]     cnt_q;
  logic [2*SIZE-1:0] product_q;
  logic              busy_q;
  logic              done_q;

  logic [SIZE-1:0]   add_y_d;
  logic [SIZE-1:0]   add_sum_d;
  logic              add_cout_d;

  // A zero addend when Q[0]=0 turns the adder into a pass-through of P_hi.
  assign add_y_d = q_q[0] ? a_q : '0;

  parametric_RCA #(.SIZE(SIZE)) u_rca (
    .x    (p_hi_q),
    .y    (add_y_d),
    .cin  (1'b0),
    .sum  (add_sum_d),
    .cout (add_cout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      p_hi_q    <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.multiplicand;
            q_q     <= bus.multiplier;
            p_hi_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ADD: begin
          p_hi_q <= {add_cout_d, add_sum_d[SIZE-1:1]};
          q_q    <= {add_sum_d[0], q_q[SIZE-1:1]};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(SIZE - 1)) begin
            // Post-shift {P_hi, Q} is the finished product; the carry is kept.
            product_q <= {add_cout_d, add_sum_d, q_q[SIZE-1:1]};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: SIZE=8 and SIZE=4 instances, expected products
// queued at the accepting edge and popped when done is observed.
module tb_shift_add_multiplier;
  logic clk;
  logic rst;
  logic [1:0] state8;
  logic [1:0] state4;

  int checks;
  int errors;

  logic [15:0] exp_q[$];
  logic [7:0]  exp4_q[$];

  shift_add_multiplier_if #(.SIZE(8)) m8 ();
  shift_add_multiplier_if #(.SIZE(4)) m4 ();

  shift_add_multiplier #(.SIZE(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (m8),
    .state_o (state8)
  );

  shift_add_multiplier #(.SIZE(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (m4),
    .state_o (state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: request one SIZE=8 multiply, then count busy cycles until done.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input string name);
    int n;
    logic busy_bad;
    logic [15:0] exp;
    m8.start        = 1'b1;
    m8.multiplicand = a;
    m8.multiplier   = b;
    exp_q.push_back(16'(a) * 16'(b));
    @(negedge clk);
    m8.start        = 1'b0;
    m8.multiplicand = 8'($urandom);
    m8.multiplier   = 8'($urandom);
    n = 0;
    busy_bad = 1'b0;
    while (!m8.done && n < 50) begin
      if (m8.busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 8 || busy_bad) begin
      errors++;
      $display("FAIL %s latency: busy cycles %0d busy_ok %0b, expected 8 busy cycles", name, n, !busy_bad);
    end
    exp = exp_q.pop_front();
    checks++;
    if (m8.done !== 1'b1 || m8.busy !== 1'b0 || m8.product !== exp) begin
      errors++;
      $display("FAIL %s product: done %0b busy %0b product %h, expected done 1 busy 0 product %h",
               name, m8.done, m8.busy, m8.product, exp);
    end
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input string name);
    int n;
    logic busy_bad;
    logic [7:0] exp;
    m4.start        = 1'b1;
    m4.multiplicand = a;
    m4.multiplier   = b;
    exp4_q.push_back(8'(a) * 8'(b));
    @(negedge clk);
    m4.start = 1'b0;
    n = 0;
    busy_bad = 1'b0;
    while (!m4.done && n < 50) begin
      if (m4.busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4 || busy_bad) begin
      errors++;
      $display("FAIL %s latency: busy cycles %0d busy_ok %0b, expected 4 busy cycles", name, n, !busy_bad);
    end
    exp = exp4_q.pop_front();
    checks++;
    if (m4.done !== 1'b1 || m4.busy !== 1'b0 || m4.product !== exp) begin
      errors++;
      $display("FAIL %s product: done %0b busy %0b product %h, expected done 1 busy 0 product %h",
               name, m4.done, m4.busy, m4.product, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (m8.busy !== 1'b0 || m8.done !== 1'b0 || m8.product !== 16'h0000 || state8 !== 2'd0) begin
      errors++;
      $display("FAIL reset_init: busy %0b done %0b product %h state %0d, expected 0 0 0000 0",
               m8.busy, m8.done, m8.product, state8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Leave a nonzero product, then pulse reset between clock edges.
    run_op8(8'd3, 8'd5, "pre_reset_op");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m8.busy !== 1'b0 || m8.done !== 1'b0 || m8.product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: busy %0b done %0b product %h, expected 0 0 0000",
               m8.busy, m8.done, m8.product);
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op8(8'd13, 8'd11, "basic_13x11");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m8.product !== 16'h008F || m8.done !== 1'b0 || m8.busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold: product %h done %0b busy %0b, expected 008f 0 0",
                 m8.product, m8.done, m8.busy);
      end
    end
  endtask

  task automatic test_corners();
    run_op8(8'd255, 8'd255, "corner_ff_ff");
    checks++;
    if (m8.product !== 16'hFE01) begin
      errors++;
      $display("FAIL corner_max_const: product %h, expected fe01", m8.product);
    end
    @(negedge clk);
    run_op8(8'd0, 8'd200, "corner_zero");
    @(negedge clk);
    run_op8(8'd200, 8'd1, "corner_one");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] exp;
    m8.start = 1'b1; m8.multiplicand = 8'd7; m8.multiplier = 8'd9;
    exp_q.push_back(16'd63);
    @(negedge clk);
    m8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Third busy cycle: this request must be ignored.
    m8.start = 1'b1; m8.multiplicand = 8'd1; m8.multiplier = 8'd1;
    @(negedge clk);
    m8.start = 1'b0;
    n = 0;
    while (!m8.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (m8.done !== 1'b1 || m8.product !== exp) begin
      errors++;
      $display("FAIL b2b_ignore: done %0b product %h, expected done 1 product %h", m8.done, m8.product, exp);
    end
    m8.start = 1'b1; m8.multiplicand = 8'd2; m8.multiplier = 8'd3;
    exp_q.push_back(16'd6);
    n = 0;
    do begin
      @(negedge clk);
      m8.start = 1'b0;
      n++;
    end while (!m8.done && n < 50);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: done spacing %0d cycles, expected 9", n);
    end
    exp = exp_q.pop_front();
    checks++;
    if (m8.done !== 1'b1 || m8.product !== exp) begin
      errors++;
      $display("FAIL b2b_second: done %0b product %h, expected done 1 product %h", m8.done, m8.product, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_add();
    logic saw_done;
    m8.start = 1'b1; m8.multiplicand = 8'd100; m8.multiplier = 8'd100;
    @(negedge clk);
    m8.start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (m8.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: busy %0b before reset, expected 1", m8.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m8.busy !== 1'b0 || m8.product !== 16'h0000 || state8 !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_abort: busy %0b product %h state %0d, expected 0 0000 0",
               m8.busy, m8.product, state8);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m8.done !== 1'b0 || m8.busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || m8.product !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_quiet: activity %0b product %h, expected no activity and product 0000",
               saw_done, m8.product);
    end
    run_op8(8'd100, 8'd100, "rst_mid_rerun");
    checks++;
    if (m8.product !== 16'h2710) begin
      errors++;
      $display("FAIL rst_mid_rerun_const: product %h, expected 2710", m8.product);
    end
    @(negedge clk);
  endtask

  task automatic test_size4();
    run_op4(4'd15, 4'd15, "size4_15x15");
    checks++;
    if (m4.product !== 8'hE1) begin
      errors++;
      $display("FAIL size4_const: product %h, expected e1", m4.product);
    end
    @(negedge clk);
    run_op4(4'd9, 4'd6, "size4_9x6");
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m8.start = 1'b0; m8.multiplicand = '0; m8.multiplier = '0;
    m4.start = 1'b0; m4.multiplicand = '0; m4.multiplier = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid_add();
    test_size4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
